ps2_key_sequencer: RTL and testbench
====================================

# ps2_key_sequencer

Controller that drains the PS/2 scan-code FIFO (`ps2_keyboard`) through its `ready`/`nextdata_n` handshake and turns raw bytes into key events. It parses `E0` (extended) and `F0` (break) prefixes, tracks the currently held key, filters typematic repeats and counts completed keystrokes. It sits between `ps2_keyboard` and the display/ASCII-lookup logic, replacing ad-hoc flag handling in the top level with a single paced state machine on the system clock.

## Interface
- `CNT_W`, default 8: width of keystroke counter.
- `clk`  in  1  system clock; all logic on rising edge, no divided clocks.
- `clrn`  in  1  reset, asynchronous, active-low.
- `ready`  in  1  FIFO non-empty, from `ps2_keyboard`.
- `data`  in  8  FIFO head byte, valid while `ready`=1.
- `overflow`  in  1  FIFO overflow flag from `ps2_keyboard`.
- `nextdata_n`  out  1  FIFO pop strobe, active-low, exactly one cycle per byte.
- `key_valid`  out  1  one-cycle pulse: new key event on `key_*`.
- `key_code`  out  8  scan code of last event (prefixes stripped).
- `key_ext`  out  1  last event carried `E0` prefix.
- `key_make`  out  1  1 = press event, 0 = release event.
- `key_repeat`  out  1  press event is typematic repeat of held key.
- `key_down`  out  1  level: a key is currently held.
- `press_count`  out  CNT_W  completed keystrokes (release events), wraps.
- `ovf_err`  out  1  sticky: `overflow` seen since reset.

## Operation
- States: IDLE, POP, GAP.
- IDLE: if `ready`=1, latch `data` into `byte_r`, go POP; else stay.
- POP: `nextdata_n`=0 for this cycle only; decode `byte_r`; go GAP.
- GAP: `nextdata_n`=1, `ready` ignored (FIFO pointer settling); go IDLE.
- Decode of `byte_r` in POP:
  - `E0`: set `ext_p`; no event.
  - `F0`: set `brk_p`; no event.
  - other, `brk_p`=0: press event. `key_repeat`=1 iff `key_down`=1 and {`ext_p`,code} equals held {ext,code}. Held key := {`ext_p`,code}; `key_down`:=1.
  - other, `brk_p`=1: release event, `key_repeat`=0. If {`ext_p`,code} equals held key: `key_down`:=0. `press_count` += 1 regardless of match (mod 2^CNT_W).
  - Any event: `key_code`,`key_ext`,`key_make` updated, `key_valid` pulses; `ext_p`,`brk_p` cleared.
- Release of non-held key (second key rolled over) does not clear `key_down`.
- `overflow`=1 in any cycle: `ovf_err`:=1, `ext_p`,`brk_p` cleared (prefix context lost); draining continues normally.
- If `overflow` coincides with a decode cycle, the decode's prefix update is overridden by the clear; its event, if any, is still emitted.
- Reset (any time, incl. mid-POP): all outputs to reset values immediately; `nextdata_n` released high; state IDLE. Bytes remaining in FIFO are processed after reset exits.

## Timing
- Reset values: `nextdata_n`=1, `key_valid`=0, `key_code`=0, `key_ext`=0, `key_make`=0, `key_repeat`=0, `key_down`=0, `press_count`=0, `ovf_err`=0; internal `ext_p`=`brk_p`=0, held key=0.
- `ready` sampled high at edge T (IDLE) → `nextdata_n` low during cycle T+1 → high at T+2.
- Event outputs registered at edge T+2 (end of POP); `key_valid` high exactly cycle T+2..T+3.
- Max throughput one byte per 3 clocks; back-to-back FIFO bytes never skipped or double-popped.
- `nextdata_n` never low two consecutive cycles; never low while FIFO state not yet re-sampled (GAP guarantees).
- Output fields hold last event value between pulses.

## Test plan
- Reset, FIFO feeds `1C F0 1C` → two pulses: (code 1C, make=1, repeat=0, down→1), (1C, make=0, down→0); `press_count`=1; exactly 3 `nextdata_n` low pulses, each 3 cycles apart.
- Feed `E0 75 E0 F0 75` → events (75, ext=1, make=1), (75, ext=1, make=0); no events for prefix bytes; `press_count`=1.
- Typematic `1C 1C 1C F0 1C` → three press pulses, repeat=0,1,1; one release; `key_down` high through repeats.
- Rollover `1C 32 F0 1C F0 32` → after `F0 1C` `key_down` stays 1 (held=32); after `F0 32` `key_down`=0; `press_count`=2.
- Send 256 `F0 1C` pairs with `CNT_W`=8 → `press_count` wraps to 0; assert `clrn` low during a POP cycle → `nextdata_n` returns 1 asynchronously, all outputs reset.
- Pulse `overflow` after `F0` byte, then `1C` → event is press (make=1), `ovf_err`=1 and stays 1 until reset.

Source files
------------

// File: rtl/ps2_key_sequencer.sv
// ps2_key_sequencer
// Drains the PS/2 scan-code FIFO one byte every three clocks through the
// ready/nextdata_n handshake. It strips E0/F0 prefixes, reports press and
// release events, flags typematic repeats of the held key, counts completed
// keystrokes and keeps a sticky record of FIFO overflow.

module ps2_key_sequencer #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             clrn,
   input  logic             ready,
   input  logic [7:0]       data,
   input  logic             overflow,
   output logic             nextdata_n,
   output logic             key_valid,
   output logic [7:0]       key_code,
   output logic             key_ext,
   output logic             key_make,
   output logic             key_repeat,
   output logic             key_down,
   output logic [CNT_W-1:0] press_count,
   output logic             ovf_err
);

   // IDLE waits for a byte, POP strobes the FIFO and decodes, GAP lets the
   // FIFO read pointer settle before ready is trusted again.
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_POP  = 2'd1,
      S_GAP  = 2'd2
   } state_e;

   localparam logic [7:0] PFX_EXT = 8'hE0;
   localparam logic [7:0] PFX_BRK = 8'hF0;

   state_e           state_q,       state_d;
   logic [7:0]       byte_q,        byte_d;
   logic             nextdata_n_q,  nextdata_n_d;

   logic             ext_p_q,       ext_p_d;
   logic             brk_p_q,       brk_p_d;
   logic             held_ext_q,    held_ext_d;
   logic [7:0]       held_code_q,   held_code_d;

   logic             key_valid_q,   key_valid_d;
   logic [7:0]       key_code_q,    key_code_d;
   logic             key_ext_q,     key_ext_d;
   logic             key_make_q,    key_make_d;
   logic             key_repeat_q,  key_repeat_d;
   logic             key_down_q,    key_down_d;
   logic [CNT_W-1:0] press_count_q, press_count_d;
   logic             ovf_err_q,     ovf_err_d;

   logic             held_match;

   // The byte being decoded, with its pending E0 context, names the held key.
   assign held_match = ({ext_p_q, byte_q} == {held_ext_q, held_code_q});

   // Handshake sequencing: latch the FIFO head, pop exactly once, then wait.
   always_comb begin
      // NOTE: every variable written here gets a default first, so no path
      // can leave it unassigned and infer a latch.
      state_d      = state_q;
      byte_d       = byte_q;
      nextdata_n_d = 1'b1;
      unique case (state_q)
         S_IDLE: begin
            if (ready) begin
               byte_d       = data;
               state_d      = S_POP;
               nextdata_n_d = 1'b0;
            end
         end
         S_POP:   state_d = S_GAP;
         S_GAP:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Byte decode in POP, plus the overflow override of prefix context.
   always_comb begin
      ext_p_d       = ext_p_q;
      brk_p_d       = brk_p_q;
      held_ext_d    = held_ext_q;
      held_code_d   = held_code_q;
      key_valid_d   = 1'b0;
      key_code_d    = key_code_q;
      key_ext_d     = key_ext_q;
      key_make_d    = key_make_q;
      key_repeat_d  = key_repeat_q;
      key_down_d    = key_down_q;
      press_count_d = press_count_q;
      ovf_err_d     = ovf_err_q;

      if (state_q == S_POP) begin
         if (byte_q == PFX_EXT) begin
            ext_p_d = 1'b1;
         end else if (byte_q == PFX_BRK) begin
            brk_p_d = 1'b1;
         end else begin
            key_valid_d = 1'b1;
            key_code_d  = byte_q;
            key_ext_d   = ext_p_q;
            ext_p_d     = 1'b0;
            brk_p_d     = 1'b0;
            if (!brk_p_q) begin
               // Press: a repeat only if the very same key is still down.
               key_make_d   = 1'b1;
               key_repeat_d = key_down_q && held_match;
               held_ext_d   = ext_p_q;
               held_code_d  = byte_q;
               key_down_d   = 1'b1;
            end else begin
               // Release: a rolled-over key leaves the newer held key down,
               // but every release still completes a keystroke.
               key_make_d    = 1'b0;
               key_repeat_d  = 1'b0;
               press_count_d = press_count_q + CNT_W'(1);
               if (held_match) begin
                  key_down_d = 1'b0;
               end
            end
         end
      end

      // A lost byte may have been a prefix, so the context can't be trusted.
      if (overflow) begin
         ovf_err_d = 1'b1;
         ext_p_d   = 1'b0;
         brk_p_d   = 1'b0;
      end
   end

   // State and handshake registers.
   always_ff @(posedge clk or negedge clrn) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      if (!clrn) begin
         state_q      <= S_IDLE;
         byte_q       <= 8'h00;
         nextdata_n_q <= 1'b1;
      end else begin
         state_q      <= state_d;
         byte_q       <= byte_d;
         nextdata_n_q <= nextdata_n_d;
      end
   end

   // Prefix context, held key and event output registers.
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         ext_p_q       <= 1'b0;
         brk_p_q       <= 1'b0;
         held_ext_q    <= 1'b0;
         held_code_q   <= 8'h00;
         key_valid_q   <= 1'b0;
         key_code_q    <= 8'h00;
         key_ext_q     <= 1'b0;
         key_make_q    <= 1'b0;
         key_repeat_q  <= 1'b0;
         key_down_q    <= 1'b0;
         press_count_q <= '0;
         ovf_err_q     <= 1'b0;
      end else begin
         ext_p_q       <= ext_p_d;
         brk_p_q       <= brk_p_d;
         held_ext_q    <= held_ext_d;
         held_code_q   <= held_code_d;
         key_valid_q   <= key_valid_d;
         key_code_q    <= key_code_d;
         key_ext_q     <= key_ext_d;
         key_make_q    <= key_make_d;
         key_repeat_q  <= key_repeat_d;
         key_down_q    <= key_down_d;
         press_count_q <= press_count_d;
         ovf_err_q     <= ovf_err_d;
      end
   end

   assign nextdata_n  = nextdata_n_q;
   assign key_valid   = key_valid_q;
   assign key_code    = key_code_q;
   assign key_ext     = key_ext_q;
   assign key_make    = key_make_q;
   assign key_repeat  = key_repeat_q;
   assign key_down    = key_down_q;
   assign press_count = press_count_q;
   assign ovf_err     = ovf_err_q;

endmodule

// File: tb/tb_ps2_key_sequencer.sv
// tb_ps2_key_sequencer
// Behavioural FIFO feeding the sequencer; expected key events are queued as
// stimulus is issued and a monitor compares each key_valid pulse in order.

module tb_ps2_key_sequencer;

   logic       clk      = 1'b0;
   logic       clrn     = 1'b0;
   logic       ready    = 1'b0;
   logic [7:0] data     = 8'h00;
   logic       overflow = 1'b0;
   logic       nextdata_n;
   logic       key_valid;
   logic [7:0] key_code;
   logic       key_ext;
   logic       key_make;
   logic       key_repeat;
   logic       key_down;
   logic [7:0] press_count;
   logic       ovf_err;

   typedef struct packed {
      logic [7:0] code;
      logic       ext;
      logic       make;
      logic       rep;
      logic       down;
      logic [7:0] cnt;
      logic       ovf;
   } ev_t;

   ev_t        exp_q[$];
   logic [7:0] fifo[$];
   int         pop_stamps[$];
   int         n_vec  = 0;
   int         n_miss = 0;
   int         cyc    = 0;
   logic       nd_neg = 1'b1;

   ps2_key_sequencer #(.CNT_W(8)) dut (
      .clk         (clk),
      .clrn        (clrn),
      .ready       (ready),
      .data        (data),
      .overflow    (overflow),
      .nextdata_n  (nextdata_n),
      .key_valid   (key_valid),
      .key_code    (key_code),
      .key_ext     (key_ext),
      .key_make    (key_make),
      .key_repeat  (key_repeat),
      .key_down    (key_down),
      .press_count (press_count),
      .ovf_err     (ovf_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_miss++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // FIFO model: pops on an edge where nextdata_n was low, head refreshed just after.
   always @(negedge clk) nd_neg = nextdata_n;

   always @(posedge clk) begin : fifo_model
      logic pop_now;
      pop_now = !nd_neg;
      #1;
      if (pop_now && fifo.size() > 0) void'(fifo.pop_front());
      ready = (fifo.size() > 0);
      data  = ready ? fifo[0] : 8'h00;
   end

   // Monitor: compare each event pulse against the scoreboard; police the pop strobe.
   logic nd_prev  = 1'b1;
   int   last_pop = -100;
   always @(negedge clk) begin : monitor
      ev_t act_ev;
      ev_t exp_ev;
      if (key_valid) begin
         act_ev = {key_code, key_ext, key_make, key_repeat, key_down, press_count, ovf_err};
         if (exp_q.size() == 0) begin
            check("unexpected_event", 32'(key_valid), 32'd0);
         end else begin
            exp_ev = exp_q.pop_front();
            check("event", 32'(act_ev), 32'(exp_ev));
         end
      end
      if (!nextdata_n) begin
         check("nd_not_consecutive", 32'(nd_prev), 32'd1);
         check("nd_gap", 32'((cyc - last_pop) >= 3), 32'd1);
         last_pop = cyc;
         pop_stamps.push_back(cyc);
      end
      nd_prev = nextdata_n;
   end

   task automatic feed(input logic [7:0] b[$]);
      foreach (b[i]) fifo.push_back(b[i]);
   endtask

   task automatic expect_ev(input logic [7:0] code, input logic ext, input logic make,
                            input logic rep, input logic down, input logic [7:0] cnt,
                            input logic ovf);
      ev_t e;
      e = {code, ext, make, rep, down, cnt, ovf};
      exp_q.push_back(e);
   endtask

   task automatic drain(input int budget);
      for (int i = 0; i < budget && fifo.size() != 0; i++) @(posedge clk);
      check("drain_timeout", 32'(fifo.size()), 32'd0);
      repeat (6) @(posedge clk);
      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_nextdata_n"},  32'(nextdata_n),  32'd1);
      check({tag, "_key_valid"},   32'(key_valid),   32'd0);
      check({tag, "_key_code"},    32'(key_code),    32'd0);
      check({tag, "_key_ext"},     32'(key_ext),     32'd0);
      check({tag, "_key_make"},    32'(key_make),    32'd0);
      check({tag, "_key_repeat"},  32'(key_repeat),  32'd0);
      check({tag, "_key_down"},    32'(key_down),    32'd0);
      check({tag, "_press_count"}, 32'(press_count), 32'd0);
      check({tag, "_ovf_err"},     32'(ovf_err),     32'd0);
   endtask

   initial begin : watchdog
      #2_000_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin : stimulus
      int found;
      repeat (3) @(negedge clk);
      check_reset("por");
      clrn = 1'b1;
      repeat (2) @(negedge clk);

      // Make/break of one key; three pops spaced exactly three cycles.
      pop_stamps.delete();
      feed('{8'h1C, 8'hF0, 8'h1C});
      expect_ev(8'h1C, 1'b0, 1'b1, 1'b0, 1'b1, 8'd0, 1'b0);
      expect_ev(8'h1C, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1, 1'b0);
      drain(100);
      check("t1_pop_count", 32'(pop_stamps.size()), 32'd3);
      if (pop_stamps.size() == 3) begin
         check("t1_spacing_a", 32'(pop_stamps[1] - pop_stamps[0]), 32'd3);
         check("t1_spacing_b", 32'(pop_stamps[2] - pop_stamps[1]), 32'd3);
      end

      // Extended key make/break; prefixes produce no event.
      feed('{8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75});
      expect_ev(8'h75, 1'b1, 1'b1, 1'b0, 1'b1, 8'd1, 1'b0);
      expect_ev(8'h75, 1'b1, 1'b0, 1'b0, 1'b0, 8'd2, 1'b0);
      drain(100);

      // Typematic repeats of a held key.
      feed('{8'h1C, 8'h1C, 8'h1C, 8'hF0, 8'h1C});
      expect_ev(8'h1C, 1'b0, 1'b1, 1'b0, 1'b1, 8'd2, 1'b0);
      expect_ev(8'h1C, 1'b0, 1'b1, 1'b1, 1'b1, 8'd2, 1'b0);
      expect_ev(8'h1C, 1'b0, 1'b1, 1'b1, 1'b1, 8'd2, 1'b0);
      expect_ev(8'h1C, 1'b0, 1'b0, 1'b0, 1'b0, 8'd3, 1'b0);
      drain(100);

      // Rollover: releasing the older key keeps key_down.
      feed('{8'h1C, 8'h32, 8'hF0, 8'h1C, 8'hF0, 8'h32});
      expect_ev(8'h1C, 1'b0, 1'b1, 1'b0, 1'b1, 8'd3, 1'b0);
      expect_ev(8'h32, 1'b0, 1'b1, 1'b0, 1'b1, 8'd3, 1'b0);
      expect_ev(8'h1C, 1'b0, 1'b0, 1'b0, 1'b1, 8'd4, 1'b0);
      expect_ev(8'h32, 1'b0, 1'b0, 1'b0, 1'b0, 8'd5, 1'b0);
      drain(100);

      // Same code with and without E0 are different keys.
      feed('{8'h1C, 8'hE0, 8'h1C, 8'hF0, 8'h1C, 8'hE0, 8'hF0, 8'h1C});
      expect_ev(8'h1C, 1'b0, 1'b1, 1'b0, 1'b1, 8'd5, 1'b0);
      expect_ev(8'h1C, 1'b1, 1'b1, 1'b0, 1'b1, 8'd5, 1'b0);
      expect_ev(8'h1C, 1'b0, 1'b0, 1'b0, 1'b1, 8'd6, 1'b0);
      expect_ev(8'h1C, 1'b1, 1'b0, 1'b0, 1'b0, 8'd7, 1'b0);
      drain(100);

      // Overflow after F0 drops the break context; ovf_err is sticky.
      feed('{8'hF0});
      drain(100);
      @(negedge clk) overflow = 1'b1;
      @(negedge clk) overflow = 1'b0;
      check("ovf_set", 32'(ovf_err), 32'd1);
      feed('{8'h1C});
      expect_ev(8'h1C, 1'b0, 1'b1, 1'b0, 1'b1, 8'd7, 1'b1);
      drain(100);
      feed('{8'hF0, 8'h1C});
      expect_ev(8'h1C, 1'b0, 1'b0, 1'b0, 1'b0, 8'd8, 1'b1);
      drain(100);
      check("ovf_sticky", 32'(ovf_err), 32'd1);

      // Reset asserted during POP releases nextdata_n at once; byte stays queued.
      feed('{8'h1C});
      found = 0;
      for (int i = 0; i < 50 && found == 0; i++) begin
         @(posedge clk);
         #1;
         if (!nextdata_n) found = 1;
      end
      check("pop_seen_before_reset", 32'(found), 32'd1);
      #1 clrn = 1'b0;
      #1 check_reset("midpop");
      repeat (2) @(negedge clk);
      clrn = 1'b1;
      expect_ev(8'h1C, 1'b0, 1'b1, 1'b0, 1'b1, 8'd0, 1'b0);
      drain(100);

      // 256 releases wrap the 8-bit counter back to zero.
      for (int k = 1; k <= 256; k++) begin
         feed('{8'hF0, 8'h1C});
         expect_ev(8'h1C, 1'b0, 1'b0, 1'b0, 1'b0, 8'(k), 1'b0);
      end
      drain(3000);
      check("count_wrap", 32'(press_count), 32'd0);
      check("down_after_wrap", 32'(key_down), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
